mem_port_arbiter: RTL

//  Shares one pipelined-Wishbone port of main_memory between fetch (read-only instr port) and the memory

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_arb_timer.sv | 24 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the single-port memory arbiter: FSM states, grant owner and
// the tie-break helper used both from IDLE and on back-to-back handover.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
  typedef enum logic {GNT_INSTR, GNT_DATA} arb_gnt_t;

  localparam int WB_SEL_W = 4;

  function automatic arb_state_t pick_grant(input logic want_d, input logic want_i,
                                            input logic prefer_i);
    if (want_d && want_i) return prefer_i ? GNT_I : GNT_D;
    if (want_d) return GNT_D;
    if (want_i) return GNT_I;
    return IDLE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data Wishbone port and the shared main_memory port.
// slave = arbiter view, master = fetch stage, memory stage and main_memory.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);
  import mem_arb_pkg::*;

  logic                instr_req;
  logic [ADDR_W-1:0]   instr_addr;
  logic                instr_flush;
  logic                instr_ack;
  logic                instr_err;
  logic [31:0]         instr_data;

  logic                dwb_cyc;
  logic                dwb_stb;
  logic                dwb_wr_en;
  logic [ADDR_W-1:0]   dwb_addr;
  logic [31:0]         dwb_wr_data;
  logic [WB_SEL_W-1:0] dwb_wr_sel;
  logic                dwb_ack;
  logic                dwb_err;
  logic                dwb_stall;
  logic [31:0]         dwb_rd_data;

  logic                mwb_cyc;
  logic                mwb_stb;
  logic                mwb_wr_en;
  logic [ADDR_W-1:0]   mwb_addr;
  logic [31:0]         mwb_wr_data;
  logic [WB_SEL_W-1:0] mwb_wr_sel;
  logic                mwb_ack;
  logic                mwb_stall;
  logic [31:0]         mwb_rd_data;

  modport slave (
    input  instr_req, instr_addr, instr_flush,
    output instr_ack, instr_err, instr_data,
    input  dwb_cyc, dwb_stb, dwb_wr_en, dwb_addr, dwb_wr_data, dwb_wr_sel,
    output dwb_ack, dwb_err, dwb_stall, dwb_rd_data,
    output mwb_cyc, mwb_stb, mwb_wr_en, mwb_addr, mwb_wr_data, mwb_wr_sel,
    input  mwb_ack, mwb_stall, mwb_rd_data
  );

  modport master (
    output instr_req, instr_addr, instr_flush,
    input  instr_ack, instr_err, instr_data,
    output dwb_cyc, dwb_stb, dwb_wr_en, dwb_addr, dwb_wr_data, dwb_wr_sel,
    input  dwb_ack, dwb_err, dwb_stall, dwb_rd_data,
    input  mwb_cyc, mwb_stb, mwb_wr_en, mwb_addr, mwb_wr_data, mwb_wr_sel,
    output mwb_ack, mwb_stall, mwb_rd_data
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Grant watchdog: counts granted cycles without ack; expire flags the cycle whose
// edge brings the count to TIMEOUT_CYCLES-1, so the error pulse lands on that count.
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined Wishbone main_memory port between fetch and the memory stage.
// Build option ARB_ROUND_ROBIN_EN: ties go to the requester not granted last.
//
//  state | meaning
//  IDLE  | bus free, mwb_cyc low
//  GNT_I | fetch owns main_memory port until ack or timeout
//  GNT_D | memory stage owns main_memory port until ack or timeout
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t state;
  arb_state_t pick;
  logic       flushed;
  logic       dropped;
  logic       granted;
  logic       want_d;
  logic       want_i;
  logic       prefer_i;
  logic       start;
  logic       timer_en;
  logic       timer_expire;

`ifdef ARB_ROUND_ROBIN_EN
  arb_gnt_t last_gnt;
  assign prefer_i = (last_gnt == GNT_DATA);
`else
  assign prefer_i = 1'b0;
`endif

  assign granted = (state != IDLE);

  // On handover, a held instr_req is the request being acked unless it was flushed.
  always_comb begin
    want_d = bus.dwb_cyc && bus.dwb_stb;
    want_i = bus.instr_req;
    case (state)
      IDLE: begin
        want_d = want_d && !bus.dwb_err;
        want_i = want_i && !bus.instr_err;
      end
      GNT_I:   want_i = want_i && (flushed || bus.instr_flush);
      GNT_D:   want_d = want_d && !bus.mwb_stb;
      default: ;
    endcase
  end

  assign pick     = pick_grant(want_d, want_i, prefer_i);
  assign start    = (state == IDLE || bus.mwb_ack) && (pick != IDLE);
  assign timer_en = granted && !bus.mwb_ack;

  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (timer_en),
    .expire (timer_expire)
  );

  assign bus.instr_ack   = (state == GNT_I) && bus.mwb_ack && !flushed && !bus.instr_flush;
  assign bus.instr_data  = bus.instr_ack ? bus.mwb_rd_data : '0;
  assign bus.dwb_ack     = (state == GNT_D) && bus.mwb_ack && bus.dwb_cyc && !dropped;
  assign bus.dwb_rd_data = bus.dwb_ack ? bus.mwb_rd_data : '0;
  assign bus.dwb_stall   = !((state == GNT_D) && bus.mwb_stb && !bus.mwb_stall);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bus.mwb_cyc     <= 1'b0;
      bus.mwb_stb     <= 1'b0;
      bus.mwb_wr_en   <= 1'b0;
      bus.mwb_addr    <= '0;
      bus.mwb_wr_data <= '0;
      bus.mwb_wr_sel  <= '0;
      bus.instr_err   <= 1'b0;
      bus.dwb_err     <= 1'b0;
      flushed         <= 1'b0;
      dropped         <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt        <= GNT_INSTR;
`endif
    end else begin
      bus.instr_err <= 1'b0;
      bus.dwb_err   <= 1'b0;
      if (granted && bus.mwb_stb && !bus.mwb_stall) bus.mwb_stb <= 1'b0;
      if (state == GNT_I && bus.instr_flush) flushed <= 1'b1;
      if (state == GNT_D && !bus.dwb_cyc)    dropped <= 1'b1;

      if (start) begin
        state       <= pick;
        bus.mwb_cyc <= 1'b1;
        bus.mwb_stb <= 1'b1;
        flushed     <= 1'b0;
        dropped     <= 1'b0;
        if (pick == GNT_D) begin
          bus.mwb_wr_en   <= bus.dwb_wr_en;
          bus.mwb_addr    <= bus.dwb_addr;
          bus.mwb_wr_data <= bus.dwb_wr_data;
          bus.mwb_wr_sel  <= bus.dwb_wr_sel;
        end else begin
          bus.mwb_wr_en   <= 1'b0;
          bus.mwb_addr    <= {bus.instr_addr[ADDR_W-1:2], 2'b00};
          bus.mwb_wr_data <= '0;
          bus.mwb_wr_sel  <= '1;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt <= (pick == GNT_D) ? GNT_DATA : GNT_INSTR;
`endif
      end else if (granted && bus.mwb_ack) begin
        state       <= IDLE;
        bus.mwb_cyc <= 1'b0;
        bus.mwb_stb <= 1'b0;
      end else if (timer_expire) begin
        state       <= IDLE;
        bus.mwb_cyc <= 1'b0;
        bus.mwb_stb <= 1'b0;
        if (state == GNT_I) bus.instr_err <= !(flushed || bus.instr_flush);
        else                bus.dwb_err   <= bus.dwb_cyc && !dropped;
      end
    end
  end

endmodule
